// File: rtl/stream_mux_nx1.sv
// rtl/stream_mux_nx1.sv - N-channel stream mux with packet locking and registered output
module stream_mux_nx1 #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int SELW  = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH-1:0]         in_last,
  output logic [N_CH-1:0]         in_ready,
  input  logic [SELW-1:0]         sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [SELW-1:0]         out_ch,
  input  logic                    out_ready
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Channel count widened by one bit so an out-of-range select can be detected.
  localparam logic [SELW:0]   N_CH_W  = (SELW+1)'(N_CH);
  localparam logic [SELW-1:0] LAST_CH = SELW'(N_CH - 1);

  logic [0:0]      state;
  logic [SELW-1:0] lock_ch;
  logic [SELW-1:0] rr_ptr;

  logic [SELW-1:0] rr_grant;
  logic            rr_found;
  logic [SELW:0]   rr_sum;
  logic [SELW-1:0] rr_cand;

  logic [SELW-1:0] grant;
  logic            grant_ok;

  logic [WIDTH-1:0] beat_data;
  logic             beat_valid;
  logic             beat_last;

  logic ld;
  logic accept;

  // Output register may load when it is empty or being drained this cycle.
  assign ld     = !out_valid || out_ready;
  assign accept = grant_ok && beat_valid && ld;

  // Round-robin search: first valid channel after the pointer, wrapping at N_CH-1.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    rr_sum   = '0;
    rr_cand  = '0;
    for (int k = 0; k < N_CH; k++) begin
      rr_sum = {1'b0, rr_ptr} + (SELW+1)'(k + 1);
      if (rr_sum >= N_CH_W) begin
        rr_sum = rr_sum - N_CH_W;
      end
      rr_cand = rr_sum[SELW-1:0];
      if (!rr_found && in_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_grant = rr_cand;
      end
    end
  end

  // Grant source: locked channel mid-packet, otherwise arbiter or external select.
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    if (state == ST_LOCKED) begin
      grant    = lock_ch;
      grant_ok = 1'b1;
    end else if (MODE == 1) begin
      grant    = rr_grant;
      grant_ok = rr_found;
    end else begin
      grant    = sel;
      grant_ok = ({1'b0, sel} < N_CH_W);
    end
  end

  // Beat mux; defaults to zero so unselected or out-of-range data never leaks.
  always_comb begin
    beat_data  = '0;
    beat_valid = 1'b0;
    beat_last  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_ok && (grant == SELW'(i))) begin
        beat_data  = in_data[i*WIDTH +: WIDTH];
        beat_valid = in_valid[i];
        beat_last  = in_last[i];
      end
    end
  end

  // Only the granted channel sees ready, and only when the output can load.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = grant_ok && ld && (grant == SELW'(i));
    end
  end

  // Packet lock FSM and round-robin pointer, both advanced on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      lock_ch <= '0;
      rr_ptr  <= LAST_CH;
    end else if (accept) begin
      if ((state == ST_IDLE) && !beat_last) begin
        state   <= ST_LOCKED;
        lock_ch <= grant;
      end else if ((state == ST_LOCKED) && beat_last) begin
        state <= ST_IDLE;
      end
      if (beat_last) begin
        rr_ptr <= grant;
      end
    end
  end

  // Output stage: loads accepted beat, empties when nothing accepted, holds under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (ld) begin
      out_valid <= accept;
      if (accept) begin
        out_data <= beat_data;
        out_last <= beat_last;
        out_ch   <= grant;
      end
    end
  end

endmodule

// File: doc/stream_mux_nx1.md
Name: stream_mux_nx1

Overview:
Parametrised N-channel stream multiplexer with valid/ready handshake, packet locking and a registered output stage. It supersedes the gate-level 4:1 mux and is used wherever several producers share one downstream consumer. Channel choice is either driven by an external select (MODE=0) or made by a built-in round-robin arbiter (MODE=1). Once a packet starts, the channel is held until its last beat.

Parameters:
N_CH, 4, number of input channels (>=2)
WIDTH, 8, data width per channel
MODE, 0, 0 = external select, 1 = round-robin arbitration
SELW, $clog2(N_CH), select/channel-index width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N_CH  per-channel beat valid
in_last  input  N_CH  per-channel last beat of packet
in_ready  output  N_CH  per-channel beat accepted when valid&ready
sel  input  SELW  channel select, MODE=0 only; ignored in MODE=1
out_data  output  WIDTH  registered output data
out_valid  output  1  registered output valid
out_last  output  1  registered last flag
out_ch  output  SELW  index of channel that produced current output beat
out_ready  input  1  downstream ready

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_ch=0, FSM=IDLE, rr pointer=N_CH-1 (first RR grant goes to ch0). Reset mid-packet aborts the packet; no beat is replayed.
- Output stage: single register. Load enable ld = !out_valid | out_ready. Beat accepted on channel g when in_valid[g] & in_ready[g]. The accepted beat appears on out_* the next cycle. Latency 1 clk. Full throughput: 1 beat/clk when out_ready is held high.
- in_ready[i] = (i == grant) & grant_ok & ld. All other bits are 0. Combinational path from out_ready to in_ready is permitted.
- If ld=1 and no beat is accepted, out_valid drops to 0. If ld=0, out_* hold stable; data must not change while out_valid & !out_ready.
- FSM states: IDLE, LOCKED.
- IDLE grant, MODE=0: grant=sel; grant_ok=(sel<N_CH). An out-of-range sel grants nothing and all in_ready are 0.
- IDLE grant, MODE=1: the first channel with in_valid set, searching from ptr+1 upward with wrap-around at N_CH-1 -> 0. grant_ok=|in_valid.
- IDLE -> LOCKED: accepted beat with in_last=0. Latch lock_ch=grant.
- IDLE stays IDLE: accepted beat with in_last=1 (single-beat packet).
- LOCKED: grant=lock_ch, grant_ok=1. sel and other channels' valids are ignored, and lock_ch's in_ready follows ld.
- LOCKED -> IDLE: accepted beat on lock_ch with in_last=1.
- RR pointer: updated to the granted channel when a packet's last beat is accepted, in both IDLE and LOCKED. MODE=0 never uses the pointer.
- A sel change while LOCKED has no effect until the packet ends. A sel change in IDLE takes effect the same cycle.
- in_valid deasserting mid-packet on lock_ch: stay LOCKED, no beat, out_valid drains.
- out_ch is registered alongside out_data. out_last equals in_last of the accepted beat.
- No X propagation: unselected in_data must never reach out_data.

Test Plan:
- MODE=0, reset then sel=2, ch2 sends single-beat 0xA5 with last=1, out_ready=1 -> out_data=0xA5, out_ch=2, out_last=1 exactly one cycle after accept; in_ready=4'b0100.
- MODE=0, ch1 3-beat packet 0x11/0x22/0x33; sel switched to 3 after beat 1 -> all three beats come from ch1 in order, then ch3 is granted on the cycle after last.
- MODE=1, all four channels always valid with single-beat packets -> out_ch sequence 0,1,2,3,0,1 at 1 beat/clk.
- MODE=1, only ch0 and ch3 valid, with ch3 sending a 2-beat packet -> order is ch0, ch3, ch3, ch0; ch0 is blocked while ch3 is LOCKED.
- Backpressure: out_ready=0 for 3 cycles with a beat held -> out_data, out_valid and out_ch stay stable and in_ready=0. On release, the next beat follows with no loss and no duplication.
- rst_n pulsed low mid-packet -> out_valid=0 immediately (async). After release, MODE=1 grants ch0 first; MODE=0 grants sel freshly; out-of-range sel keeps in_ready all 0.
